vanilla_sb_clear_scheduler: RTL and testbench
=============================================

VANILLA_SB_CLEAR_SCHEDULER -- requirements
Module: vanilla_sb_clear_scheduler

Interface
REQ-001 SHALL have parameter reg_addr_width_p, default 5: register id width.
REQ-002 SHALL have parameter credit_max_p, default 16: maximum outstanding remote loads, valid range 1..63.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports issue_v_i, input, 1: a remote load/amo leaves ID this cycle; credit_avail_o, output, 1: issue permitted.
REQ-006 SHALL have ports remote_v_i, input, 1; remote_is_float_i, input, 1; remote_id_i, input, reg_addr_width_p; remote_ready_o, output, 1: remote response writeback handshake.
REQ-007 SHALL have ports idiv_v_i, input, 1; idiv_id_i, input, reg_addr_width_p; idiv_yumi_o, output, 1: idiv completion.
REQ-008 SHALL have ports fdiv_v_i, input, 1; fdiv_id_i, input, reg_addr_width_p; fdiv_yumi_o, output, 1: fdiv/fsqrt completion.
REQ-009 SHALL have ports int_wb_busy_i and float_wb_busy_i, input, 1: pipeline owns that regfile write port this cycle.
REQ-010 SHALL have ports int_sb_clear_o, output, 1; int_sb_clear_id_o, output, reg_addr_width_p; float_sb_clear_o, output, 1; float_sb_clear_id_o, output, reg_addr_width_p.
REQ-011 SHALL have ports outstanding_o, output, 6: live credit count; error_o, output, 1: sticky credit error.

Function
REQ-012 Remote responses SHALL enter a 2-entry in-order FIFO {is_float,id}; remote_ready_o = ~full, no bypass; an entry enqueued in cycle N is eligible at cycle N+1.
REQ-013 Int port contenders: FIFO head when head is int, and idiv_v_i; float port contenders: FIFO head when float, and fdiv_v_i; each port grants at most one per cycle.
REQ-014 A port with its *_wb_busy_i high SHALL grant nothing that cycle; a blocked head blocks later FIFO entries (no reordering).
REQ-015 Each port SHALL arbitrate by 2-way round-robin: after granting one contender, the other has priority next time both request; pointers reset to remote-first.
REQ-016 idiv_yumi_o/fdiv_yumi_o SHALL be combinational grants in the cycle of grant; a remote grant dequeues the FIFO head in that cycle.
REQ-017 *_sb_clear_o and *_sb_clear_id_o SHALL be registered: asserted for exactly one cycle, the cycle after grant, with the granted id.
REQ-018 Credit counter: +1 on issue_v_i, -1 on remote grant; both in the same cycle leaves it unchanged.
REQ-019 credit_avail_o = (count < credit_max_p), combinational from the count register.
REQ-020 issue_v_i at count == credit_max_p (without a simultaneous decrement) SHALL hold the count and set error_o; a decrement at count 0 SHALL hold 0 and set error_o.
REQ-021 error_o SHALL remain set until reset.

Reset
REQ-022 Asserting reset_n_i low SHALL immediately clear the FIFO, count, error_o, clear outputs and pointers, regardless of any in-flight handshake; remote_ready_o = 1 and credit_avail_o = 1 while held.
REQ-023 Responses and clears in flight at reset are discarded; the first grant is possible in the first clock edge after release.

Configuration
REQ-024 Macro VANILLA_SB_SCHED_FIXED_PRIO_EN, when defined, SHALL replace round-robin with fixed priority: remote head always beats idiv/fdiv on its port.
REQ-025 Without VANILLA_SB_SCHED_FIXED_PRIO_EN, REQ-015 round-robin applies; all other behaviour is identical.

Verification
REQ-026 Reset release, remote_v_i int id=5 -> int_sb_clear_o high with id 5 exactly two cycles later; outstanding_o 1 -> 0.
REQ-027 Remote int id=3 head and idiv_v_i id=7 simultaneously, repeated -> grants alternate 3 then 7 (round-robin); with FIXED_PRIO_EN, 3 is granted first and idiv waits until the FIFO has no int head.
REQ-028 int_wb_busy_i held 3 cycles with int head, then float entry behind it -> no clears during busy; int clear precedes float clear.
REQ-029 16 issues with no responses -> credit_avail_o = 0, outstanding_o = 16; a 17th issue -> error_o = 1, count stays 16.
REQ-030 Two queued responses, reset_n_i pulled low mid-cycle -> outputs clear immediately, no clear pulse after release, outstanding_o = 0.

Source files
------------

// File: rtl/vanilla_sb_clear_scheduler.sv
// vanilla_sb_clear_scheduler
// Schedules scoreboard-clear writebacks for remote load responses and idiv/fdiv
// completions onto the int and float regfile write ports, and tracks remote-load credits.
// Build option: define VANILLA_SB_SCHED_FIXED_PRIO_EN to make the remote FIFO head always
// win its port instead of the default 2-way round-robin.
module vanilla_sb_clear_scheduler #(
    parameter int reg_addr_width_p = 5,
    parameter int credit_max_p     = 16
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic                        issue_v_i,
    output logic                        credit_avail_o,

    input  logic                        remote_v_i,
    input  logic                        remote_is_float_i,
    input  logic [reg_addr_width_p-1:0] remote_id_i,
    output logic                        remote_ready_o,

    input  logic                        idiv_v_i,
    input  logic [reg_addr_width_p-1:0] idiv_id_i,
    output logic                        idiv_yumi_o,

    input  logic                        fdiv_v_i,
    input  logic [reg_addr_width_p-1:0] fdiv_id_i,
    output logic                        fdiv_yumi_o,

    input  logic                        int_wb_busy_i,
    input  logic                        float_wb_busy_i,

    output logic                        int_sb_clear_o,
    output logic [reg_addr_width_p-1:0] int_sb_clear_id_o,
    output logic                        float_sb_clear_o,
    output logic [reg_addr_width_p-1:0] float_sb_clear_id_o,

    output logic [5:0]                  outstanding_o,
    output logic                        error_o
);

    localparam logic [5:0] credit_max_lp = 6'(credit_max_p);

    typedef struct packed {
        logic                        is_float;
        logic [reg_addr_width_p-1:0] id;
    } entry_t;

    // Saturating credit update: returns {error, next_count}. Simultaneous issue and
    // return cancel; overflow past the maximum or underflow below zero holds and flags.
    function automatic logic [6:0] credit_next(input logic [5:0] cnt,
                                               input logic       inc,
                                               input logic       dec);
        logic [6:0] res;
        res = {1'b0, cnt};
        if (inc && !dec) begin
            if (cnt >= credit_max_lp) res = {1'b1, cnt};
            else                      res = {1'b0, cnt + 6'd1};
        end else if (dec && !inc) begin
            if (cnt == 6'd0) res = {1'b1, cnt};
            else             res = {1'b0, cnt - 6'd1};
        end
        return res;
    endfunction

    entry_t     fifo_mem [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] fifo_cnt_q;
    logic [5:0] credit_cnt_q;
    logic       error_q;

    logic       fifo_full, fifo_empty, enq, deq;
    entry_t     head;
    logic       head_int, head_flt;
    logic       int_pick_remote, flt_pick_remote;
    logic       int_grant_remote, int_grant_idiv;
    logic       flt_grant_remote, flt_grant_fdiv;
    logic [6:0] credit_upd;

    logic                        int_clr_vld_p1, flt_clr_vld_p1;
    logic [reg_addr_width_p-1:0] int_clr_id_p1, flt_clr_id_p1;

`ifndef VANILLA_SB_SCHED_FIXED_PRIO_EN
    logic int_prio_remote_q, flt_prio_remote_q;
`endif

    // Per-port arbitration: only the FIFO head competes, so a blocked head stalls the queue.
    always_comb begin
        fifo_full  = (fifo_cnt_q == 2'd2);
        fifo_empty = (fifo_cnt_q == 2'd0);
        head       = fifo_mem[rd_ptr_q];
        head_int   = ~fifo_empty & ~head.is_float;
        head_flt   = ~fifo_empty &  head.is_float;
`ifdef VANILLA_SB_SCHED_FIXED_PRIO_EN
        int_pick_remote = head_int;
        flt_pick_remote = head_flt;
`else
        int_pick_remote = head_int & (int_prio_remote_q | ~idiv_v_i);
        flt_pick_remote = head_flt & (flt_prio_remote_q | ~fdiv_v_i);
`endif
        int_grant_remote = ~int_wb_busy_i   & int_pick_remote;
        int_grant_idiv   = ~int_wb_busy_i   & idiv_v_i & ~int_pick_remote;
        flt_grant_remote = ~float_wb_busy_i & flt_pick_remote;
        flt_grant_fdiv   = ~float_wb_busy_i & fdiv_v_i & ~flt_pick_remote;
        deq        = int_grant_remote | flt_grant_remote;
        enq        = remote_v_i & ~fifo_full;
        credit_upd = credit_next(credit_cnt_q, issue_v_i, deq);
    end

    assign remote_ready_o      = ~fifo_full;
    assign idiv_yumi_o         = int_grant_idiv;
    assign fdiv_yumi_o         = flt_grant_fdiv;
    assign credit_avail_o      = (credit_cnt_q < credit_max_lp);
    assign outstanding_o       = credit_cnt_q;
    assign error_o             = error_q;
    assign int_sb_clear_o      = int_clr_vld_p1;
    assign int_sb_clear_id_o   = int_clr_id_p1;
    assign float_sb_clear_o    = flt_clr_vld_p1;
    assign float_sb_clear_id_o = flt_clr_id_p1;

    // FIFO payload storage: data only, validity is carried by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (enq) fifo_mem[wr_ptr_q] <= '{is_float: remote_is_float_i, id: remote_id_i};
    end

    // FIFO pointers, credit counter and sticky error.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            fifo_cnt_q   <= 2'd0;
            credit_cnt_q <= 6'd0;
            error_q      <= 1'b0;
        end else begin
            if (enq) wr_ptr_q <= ~wr_ptr_q;
            if (deq) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q   <= fifo_cnt_q + {1'b0, enq} - {1'b0, deq};
            credit_cnt_q <= credit_upd[5:0];
            error_q      <= error_q | credit_upd[6];
        end
    end

`ifndef VANILLA_SB_SCHED_FIXED_PRIO_EN
    // Round-robin pointers: the loser of the latest grant on each port goes first next time.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_prio_remote_q <= 1'b1;
            flt_prio_remote_q <= 1'b1;
        end else begin
            if (int_grant_remote)    int_prio_remote_q <= 1'b0;
            else if (int_grant_idiv) int_prio_remote_q <= 1'b1;
            if (flt_grant_remote)    flt_prio_remote_q <= 1'b0;
            else if (flt_grant_fdiv) flt_prio_remote_q <= 1'b1;
        end
    end
`endif

    // Stage p0 -> p1: grants become one-cycle scoreboard-clear pulses.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            int_clr_vld_p1 <= 1'b0;
            int_clr_id_p1  <= '0;
            flt_clr_vld_p1 <= 1'b0;
            flt_clr_id_p1  <= '0;
        end else begin
            int_clr_vld_p1 <= int_grant_remote | int_grant_idiv;
            int_clr_id_p1  <= int_grant_remote ? head.id : idiv_id_i;
            flt_clr_vld_p1 <= flt_grant_remote | flt_grant_fdiv;
            flt_clr_id_p1  <= flt_grant_remote ? head.id : fdiv_id_i;
        end
    end

endmodule

// File: tb/tb_vanilla_sb_clear_scheduler.sv
// Testbench for vanilla_sb_clear_scheduler: directed scenarios plus random traffic,
// checked each cycle against a queue-based reference model of the scheduling rules.
module tb_vanilla_sb_clear_scheduler;

    localparam int AW  = 5;
    localparam int MAX = 16;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          issue_v_i, credit_avail_o;
    logic          remote_v_i, remote_is_float_i, remote_ready_o;
    logic [AW-1:0] remote_id_i;
    logic          idiv_v_i, idiv_yumi_o, fdiv_v_i, fdiv_yumi_o;
    logic [AW-1:0] idiv_id_i, fdiv_id_i;
    logic          int_wb_busy_i, float_wb_busy_i;
    logic          int_sb_clear_o, float_sb_clear_o;
    logic [AW-1:0] int_sb_clear_id_o, float_sb_clear_id_o;
    logic [5:0]    outstanding_o;
    logic          error_o;

    vanilla_sb_clear_scheduler #(.reg_addr_width_p(AW), .credit_max_p(MAX)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .issue_v_i(issue_v_i), .credit_avail_o(credit_avail_o),
        .remote_v_i(remote_v_i), .remote_is_float_i(remote_is_float_i),
        .remote_id_i(remote_id_i), .remote_ready_o(remote_ready_o),
        .idiv_v_i(idiv_v_i), .idiv_id_i(idiv_id_i), .idiv_yumi_o(idiv_yumi_o),
        .fdiv_v_i(fdiv_v_i), .fdiv_id_i(fdiv_id_i), .fdiv_yumi_o(fdiv_yumi_o),
        .int_wb_busy_i(int_wb_busy_i), .float_wb_busy_i(float_wb_busy_i),
        .int_sb_clear_o(int_sb_clear_o), .int_sb_clear_id_o(int_sb_clear_id_o),
        .float_sb_clear_o(float_sb_clear_o), .float_sb_clear_id_o(float_sb_clear_id_o),
        .outstanding_o(outstanding_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    typedef struct { bit f; logic [AW-1:0] id; } resp_t;
    resp_t         mq[$];
    int            m_cnt;
    bit            m_err;
    bit            int_remote_turn, flt_remote_turn;
    bit            exp_int_clr, exp_flt_clr;
    logic [AW-1:0] exp_int_id, exp_flt_id;
    bit            last_idiv_granted, last_fdiv_granted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt = 0;
        m_err = 0;
        int_remote_turn = 1;
        flt_remote_turn = 1;
        exp_int_clr = 0;
        exp_flt_clr = 0;
        exp_int_id  = '0;
        exp_flt_id  = '0;
    endtask

    // Which contender a port serves this cycle: {remote, divider}.
    function automatic bit [1:0] arb(input bit rem, input bit div, input bit busy, input bit remote_turn);
        if (busy) return 2'b00;
`ifdef VANILLA_SB_SCHED_FIXED_PRIO_EN
        if (rem) return 2'b10;
        return {1'b0, div};
`else
        if (rem && div) return remote_turn ? 2'b10 : 2'b01;
        return {rem, div};
`endif
    endfunction

    // One clock cycle: drive at the falling edge, check, advance the model, wait a cycle.
    task automatic step(input bit iss, input bit rv, input bit rf, input logic [AW-1:0] rid,
                        input bit dv, input logic [AW-1:0] did, input bit fv, input logic [AW-1:0] fid,
                        input bit ib, input bit fb);
        bit       ready, h_int, h_flt, dec;
        bit [1:0] gi, gf;
        issue_v_i = iss; remote_v_i = rv; remote_is_float_i = rf; remote_id_i = rid;
        idiv_v_i = dv; idiv_id_i = did; fdiv_v_i = fv; fdiv_id_i = fid;
        int_wb_busy_i = ib; float_wb_busy_i = fb;
        #1;
        ready = (mq.size() < 2);
        h_int = (mq.size() > 0) && !mq[0].f;
        h_flt = (mq.size() > 0) &&  mq[0].f;
        gi = arb(h_int, dv, ib, int_remote_turn);
        gf = arb(h_flt, fv, fb, flt_remote_turn);
        check("remote_ready", 32'(remote_ready_o), 32'(ready));
        check("credit_avail", 32'(credit_avail_o), 32'(m_cnt < MAX));
        check("outstanding", 32'(outstanding_o), 32'(m_cnt));
        check("error", 32'(error_o), 32'(m_err));
        check("idiv_yumi", 32'(idiv_yumi_o), 32'(gi[0]));
        check("fdiv_yumi", 32'(fdiv_yumi_o), 32'(gf[0]));
        check("int_clear", 32'(int_sb_clear_o), 32'(exp_int_clr));
        check("float_clear", 32'(float_sb_clear_o), 32'(exp_flt_clr));
        if (exp_int_clr) check("int_clear_id", 32'(int_sb_clear_id_o), 32'(exp_int_id));
        if (exp_flt_clr) check("float_clear_id", 32'(float_sb_clear_id_o), 32'(exp_flt_id));
        // advance model to the next cycle
        exp_int_clr = gi[1] | gi[0];
        exp_flt_clr = gf[1] | gf[0];
        if (gi[1]) exp_int_id = mq[0].id; else exp_int_id = did;
        if (gf[1]) exp_flt_id = mq[0].id; else exp_flt_id = fid;
        if (gi[1]) int_remote_turn = 0; else if (gi[0]) int_remote_turn = 1;
        if (gf[1]) flt_remote_turn = 0; else if (gf[0]) flt_remote_turn = 1;
        last_idiv_granted = gi[0];
        last_fdiv_granted = gf[0];
        dec = gi[1] | gf[1];
        if (dec) void'(mq.pop_front());
        if (rv && ready) mq.push_back('{rf, rid});
        if (iss && !dec) begin
            if (m_cnt == MAX) m_err = 1; else m_cnt++;
        end else if (dec && !iss) begin
            if (m_cnt == 0) m_err = 1; else m_cnt--;
        end
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic issue(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, '0, 0, '0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        issue_v_i = 0; remote_v_i = 0; remote_is_float_i = 0; remote_id_i = '0;
        idiv_v_i = 0; idiv_id_i = '0; fdiv_v_i = 0; fdiv_id_i = '0;
        int_wb_busy_i = 0; float_wb_busy_i = 0;
        reset_n_i = 0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(remote_ready_o), 32'd1);
        check({tag, "_credit_avail"}, 32'(credit_avail_o), 32'd1);
        check({tag, "_outstanding"}, 32'(outstanding_o), 32'd0);
        check({tag, "_error"}, 32'(error_o), 32'd0);
        check({tag, "_int_clear"}, 32'(int_sb_clear_o), 32'd0);
        check({tag, "_float_clear"}, 32'(float_sb_clear_o), 32'd0);
    endtask

    initial begin
        bit            dv_pend, fv_pend, iss, rv, rf, ib, fb;
        logic [AW-1:0] dv_id, fv_id, rid;

        // reset state while held
        do_reset();
        reset_n_i = 0;
        #1;
        check_reset_outputs("rst_hold");
        @(negedge clk_i);
        reset_n_i = 1;

        // single int response: clear two cycles after it is presented
        issue(1);
        step(0, 1, 0, 5'd5, 0, '0, 0, '0, 0, 0);
        idle(3);

        // remote head vs idiv contention, repeated
        do_reset();
        issue(4);
        step(0, 1, 0, 5'd3, 0, '0, 0, '0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 5'd3, 1, 5'd7, 0, '0, 0, 0);
        idle(4);
        // same on the float port
        step(0, 1, 1, 5'd11, 0, '0, 0, '0, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 1, 5'd11, 0, '0, 1, 5'd20, 0, 0);
        idle(4);

        // int port busy with int head, float entry queued behind it
        do_reset();
        issue(3);
        step(0, 1, 0, 5'd9, 0, '0, 0, '0, 1, 0);
        step(0, 1, 1, 5'd12, 0, '0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 0, '0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 0, '0, 0, '0, 1, 0);
        idle(4);

        // credit saturation and overflow
        do_reset();
        issue(MAX);
        issue(1);
        idle(2);
        check("sat_outstanding", 32'(outstanding_o), 32'(MAX));
        check("sat_error", 32'(error_o), 32'd1);

        // credit underflow: response with no outstanding issue
        do_reset();
        step(0, 1, 0, 5'd1, 0, '0, 0, '0, 0, 0);
        idle(3);

        // asynchronous reset mid-cycle with queued responses and a clear pulse live
        do_reset();
        issue(3);
        step(0, 1, 0, 5'd4, 0, '0, 0, '0, 1, 0);
        step(0, 1, 1, 5'd6, 0, '0, 0, '0, 1, 0);
        step(0, 0, 0, '0, 0, '0, 0, '0, 0, 0);
        #2;
        reset_n_i = 0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        @(negedge clk_i);
        reset_n_i = 1;
        idle(4);

        // randomized traffic
        do_reset();
        dv_pend = 0; fv_pend = 0; dv_id = '0; fv_id = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!dv_pend && ($urandom_range(3) == 0)) begin dv_pend = 1; dv_id = AW'($urandom); end
            if (!fv_pend && ($urandom_range(3) == 0)) begin fv_pend = 1; fv_id = AW'($urandom); end
            iss = (m_cnt < MAX) && ($urandom_range(2) == 0);
            rv  = ((m_cnt - mq.size()) > 0) && ($urandom_range(1) == 0);
            rf  = 1'($urandom);
            rid = AW'($urandom);
            ib  = ($urandom_range(3) == 0);
            fb  = ($urandom_range(3) == 0);
            step(iss, rv, rf, rid, dv_pend, dv_id, fv_pend, fv_id, ib, fb);
            if (last_idiv_granted) dv_pend = 0;
            if (last_fdiv_granted) fv_pend = 0;
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
